// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the icache line refill master.
package icache_refill_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // Number of address bits that select a word inside a line.
    function automatic int unsigned offs_bits(input int unsigned wpl);
        return $clog2(wpl);
    endfunction

endpackage

// File: rtl/icache_refill_master_if.sv
// Word-wide memory port (CEN/A/GNT/WEN/D/BE/Q/RVAL) between refill master and memory.
interface icache_refill_master_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  CEN;
    logic [ADDR_WIDTH-1:0] A;
    logic                  GNT;
    logic                  WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [BE_WIDTH-1:0]   BE;
    logic [DATA_WIDTH-1:0] Q;
    logic                  RVAL;

    modport master (output CEN, A, WEN, D, BE, input GNT, Q, RVAL);
    modport slave  (input CEN, A, WEN, D, BE, output GNT, Q, RVAL);
endinterface

// File: rtl/icache_refill_master.sv
// Fetches one cache line as single-word reads, critical word first, and presents the
// assembled line to the icache.
module icache_refill_master
    import icache_refill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned WORDS_PER_LINE = 4,
    localparam int unsigned OFFS          = offs_bits(WORDS_PER_LINE)
) (
    input  logic                                     CLK,
    input  logic                                     INITN,
    input  logic                                     req_valid_i,
    output logic                                     req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                    req_addr_i,
    output logic                                     line_valid_o,
    input  logic                                     line_ready_i,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0]     line_data_o,
    output logic [ADDR_WIDTH-OFFS-1:0]               line_addr_o,
    output logic                                     err_o,
    icache_refill_master_if.master                   mem
);

    localparam logic [OFFS:0] LastIss = (OFFS + 1)'(WORDS_PER_LINE - 1);
    localparam logic [OFFS:0] FullCnt = (OFFS + 1)'(WORDS_PER_LINE);

    state_e                                       state_q, state_d;
    logic [OFFS:0]                                iss_cnt_q, iss_cnt_d;
    logic [OFFS:0]                                rx_cnt_q, rx_cnt_d;
    logic [OFFS-1:0]                              offs_q, offs_d;
    logic [ADDR_WIDTH-OFFS-1:0]                   line_q, line_d;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]    buf_q, buf_d;
    logic                                         err_q, err_d;
    logic                                         first_q;
    logic [OFFS-1:0]                              iss_word, rx_word;

    // Word positions wrap inside the line; the line address is never incremented.
    assign iss_word = offs_q + iss_cnt_q[OFFS-1:0];
    assign rx_word  = offs_q + rx_cnt_q[OFFS-1:0];

    assign mem.A       = {line_q, iss_word};
    assign mem.WEN     = 1'b1;
    assign mem.D       = '0;
    assign mem.BE      = {BE_WIDTH{1'b1}};
    assign line_data_o = buf_q;
    assign line_addr_o = line_q;
    assign err_o       = err_q;

    // Next-state, response capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        iss_cnt_d    = iss_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        offs_d       = offs_q;
        line_d       = line_q;
        buf_d        = buf_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        line_valid_o = 1'b0;
        mem.CEN      = 1'b1;

        // A response left over from before reset release is ignored without flagging.
        if (mem.RVAL && !first_q) begin
            if (rx_cnt_q < iss_cnt_q) begin
                buf_d[rx_word] = mem.Q;
                rx_cnt_d       = rx_cnt_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    line_d    = req_addr_i[ADDR_WIDTH-1:OFFS];
                    offs_d    = req_addr_i[OFFS-1:0];
                    iss_cnt_d = '0;
                    rx_cnt_d  = '0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                mem.CEN = 1'b0;
                if (mem.GNT) begin
                    iss_cnt_d = iss_cnt_q + 1'b1;
                    if (iss_cnt_q == LastIss) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Look at the updated count so the last response moves us on this cycle.
                if (rx_cnt_d == FullCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                line_valid_o = 1'b1;
                if (line_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters, line buffer and sticky error.
    always_ff @(posedge CLK or negedge INITN) begin
        if (!INITN) begin
            state_q   <= StIdle;
            iss_cnt_q <= '0;
            rx_cnt_q  <= '0;
            offs_q    <= '0;
            line_q    <= '0;
            buf_q     <= '0;
            err_q     <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            iss_cnt_q <= iss_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            offs_q    <= offs_d;
            line_q    <= line_d;
            buf_q     <= buf_d;
            err_q     <= err_d;
            first_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_refill_master.sv
// Randomized scoreboard bench for icache_refill_master with a behavioural memory model.
module tb_icache_refill_master;

    localparam int AW   = 12;
    localparam int DW   = 64;
    localparam int WPL  = 4;
    localparam int OFFS = 2;
    localparam int LW   = WPL * DW;

    logic CLK   = 1'b0;
    logic INITN = 1'b0;
    always #5 CLK = ~CLK;

    logic              req_valid_i  = 1'b0;
    logic              req_ready_o;
    logic [AW-1:0]     req_addr_i   = '0;
    logic              line_valid_o;
    logic              line_ready_i = 1'b0;
    logic [LW-1:0]     line_data_o;
    logic [AW-OFFS-1:0] line_addr_o;
    logic              err_o;

    icache_refill_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    icache_refill_master dut (
        .CLK          (CLK),
        .INITN        (INITN),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .line_valid_o (line_valid_o),
        .line_ready_i (line_ready_i),
        .line_data_o  (line_data_o),
        .line_addr_o  (line_addr_o),
        .err_o        (err_o),
        .mem          (mem_bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [DW-1:0] memory [0:(1<<AW)-1];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none/in time (t=%0t)", name, $time);
    endtask

    // Memory slave: answers a grant with data exactly one cycle later.
    int            gnt_pct     = 100;
    bit            inject_rval = 1'b0;
    bit            lat_chk     = 1'b1;
    logic          pend        = 1'b0;
    logic [AW-1:0] pend_addr   = '0;

    always @(negedge CLK) begin
        if (!INITN) begin
            pend         = 1'b0;
            mem_bus.GNT  = 1'b0;
            mem_bus.RVAL = inject_rval;
            mem_bus.Q    = '0;
        end else begin
            mem_bus.RVAL = pend || inject_rval;
            mem_bus.Q    = pend ? memory[pend_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
            mem_bus.GNT  = ($urandom_range(99) < gnt_pct);
            pend         = !mem_bus.CEN && mem_bus.GNT;
            pend_addr    = mem_bus.A;
        end
    end

    // Reference model: expected grant addresses and assembled line per request.
    typedef struct packed {
        logic [AW-OFFS-1:0] la;
        logic [LW-1:0]      data;
    } line_t;

    line_t         sb[$];
    logic [AW-1:0] aq[$];

    task automatic model_push(input logic [AW-1:0] addr);
        int    line_no;
        int    o;
        line_t e;
        line_no = int'(addr) / WPL;
        o       = int'(addr) % WPL;
        e.la    = (AW-OFFS)'(line_no);
        for (int k = 0; k < WPL; k++) begin
            aq.push_back(AW'(line_no * WPL + (o + k) % WPL));
            e.data[k*DW +: DW] = memory[line_no * WPL + k];
        end
        sb.push_back(e);
    endtask

    // Monitor: samples just after the falling edge.
    logic          prev_hold = 1'b0;
    logic          prev_lv   = 1'b0;
    logic [AW-1:0] prev_a    = '0;
    logic [LW-1:0] prev_data = '0;
    int            accept_cyc = 0;

    always begin
        @(negedge CLK);
        #1;
        if (!INITN) begin
            sb.delete();
            aq.delete();
            prev_hold = 1'b0;
            prev_lv   = 1'b0;
        end else begin
            if (prev_hold) begin
                check("a_held", LW'(mem_bus.A), LW'(prev_a));
                check("cen_held", LW'(mem_bus.CEN), LW'(0));
            end
            if (!mem_bus.CEN && mem_bus.GNT) begin
                if (aq.size() == 0) fail("extra_grant");
                else check("grant_addr", LW'(mem_bus.A), LW'(aq.pop_front()));
            end
            if (line_valid_o && !prev_lv) begin
                check("grant_count", LW'(aq.size()), LW'(0));
                if (lat_chk) check("latency", LW'(cyc - accept_cyc), LW'(6));
            end
            if (line_valid_o && prev_lv) begin
                check("line_stable", line_data_o, prev_data);
            end
            if (line_valid_o && line_ready_i) begin
                if (sb.size() == 0) fail("unexpected_line");
                else begin
                    line_t e;
                    e = sb.pop_front();
                    check("line_data", line_data_o, e.data);
                    check("line_addr", LW'(line_addr_o), LW'(e.la));
                end
            end
            if (req_valid_i && req_ready_o) begin
                model_push(req_addr_i);
                accept_cyc = cyc;
            end
            prev_hold = !mem_bus.CEN && !mem_bus.GNT;
            prev_a    = mem_bus.A;
            prev_lv   = line_valid_o;
            prev_data = line_data_o;
        end
    end

    task automatic wait_line();
        int n = 0;
        while (!line_valid_o && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!line_valid_o) fail("line_timeout");
    endtask

    task automatic refill(input logic [AW-1:0] addr, input int stall);
        int n = 0;
        @(negedge CLK);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        while (!req_ready_o && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready_o) fail("accept_timeout");
        @(negedge CLK);
        req_valid_i = 1'b0;
        wait_line();
        repeat (stall) @(negedge CLK);
        line_ready_i = 1'b1;
        @(negedge CLK);
        line_ready_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) memory[i] = {$urandom, $urandom};

        // Reset values, with a stray RVAL held across reset release.
        inject_rval = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_req_ready", LW'(req_ready_o), LW'(1));
        check("rst_line_valid", LW'(line_valid_o), LW'(0));
        check("rst_cen", LW'(mem_bus.CEN), LW'(1));
        check("rst_a", LW'(mem_bus.A), LW'(0));
        check("rst_err", LW'(err_o), LW'(0));
        check("rst_line_data", line_data_o, LW'(0));
        check("const_wen_be_d", LW'({mem_bus.WEN, mem_bus.BE, mem_bus.D}),
              LW'({1'b1, 8'hFF, 64'h0}));
        #1 INITN = 1'b1;
        @(posedge CLK);
        #1 inject_rval = 1'b0;
        @(negedge CLK);
        check("first_cycle_rval_silent", LW'(err_o), LW'(0));

        // Directed refills with GNT always high.
        gnt_pct = 100;
        lat_chk = 1'b1;
        refill(12'h010, 0);
        refill(12'h016, 1);

        // Line held in DONE with a second request waiting.
        @(negedge CLK);
        req_valid_i = 1'b1;
        req_addr_i  = 12'h123;
        @(negedge CLK);
        req_valid_i = 1'b0;
        wait_line();
        req_valid_i = 1'b1;
        req_addr_i  = 12'h2A5;
        repeat (10) begin
            @(negedge CLK);
            check("stall_line_valid", LW'(line_valid_o), LW'(1));
            check("stall_req_ready", LW'(req_ready_o), LW'(0));
        end
        line_ready_i = 1'b1;
        check("handoff_req_ready", LW'(req_ready_o), LW'(0));
        @(negedge CLK);
        line_ready_i = 1'b0;
        check("next_accept_ready", LW'(req_ready_o), LW'(1));
        @(negedge CLK);
        req_valid_i = 1'b0;
        wait_line();
        line_ready_i = 1'b1;
        @(negedge CLK);
        line_ready_i = 1'b0;

        // Unrequested response in IDLE sets a sticky error.
        @(posedge CLK);
        #1 inject_rval = 1'b1;
        @(posedge CLK);
        #1 inject_rval = 1'b0;
        @(negedge CLK);
        check("err_set", LW'(err_o), LW'(1));
        refill(12'h3F1, 0);
        check("err_sticky", LW'(err_o), LW'(1));

        // Random grants, addresses and consumer stalls.
        gnt_pct = 50;
        lat_chk = 1'b0;
        for (int i = 0; i < 24; i++) begin
            refill(AW'($urandom_range((1 << AW) - 1)), int'($urandom_range(3)));
        end
        check("err_still_sticky", LW'(err_o), LW'(1));

        // Reset after two grants of a refill.
        gnt_pct = 100;
        lat_chk = 1'b1;
        @(negedge CLK);
        req_valid_i = 1'b1;
        req_addr_i  = 12'h0A7;
        @(negedge CLK);
        req_valid_i = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 INITN = 1'b0;
        #1;
        check("midrst_cen", LW'(mem_bus.CEN), LW'(1));
        check("midrst_line_valid", LW'(line_valid_o), LW'(0));
        check("midrst_req_ready", LW'(req_ready_o), LW'(1));
        @(negedge CLK);
        #2 INITN = 1'b1;
        @(negedge CLK);
        check("midrst_err_cleared", LW'(err_o), LW'(0));
        refill(12'h0A7, 0);
        check("post_rst_err", LW'(err_o), LW'(0));

        repeat (3) @(negedge CLK);
        check("sb_empty", LW'(sb.size()), LW'(0));
        check("aq_empty", LW'(aq.size()), LW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
